npu_apb_splitter: RTL and testbench
===================================

// Module: npu_apb_splitter
// PURPOSE
//   Parametrised APB4 1-to-N splitter: one upstream APB slave port, N_SLV downstream APB master ports.
//   Decodes address into per-slave windows, runs a registered SETUP/ACCESS sequence to the hit slave.
//   Returns PSLVERR on decode miss or slave timeout. Sits between the NPU host APB bridge and NPU CSR blocks.
// PARAMETERS
//   APB_A_W      32               address width (defaults to npu_pkg::APB_A_W)
//   APB_D_W      32               data width, multiple of 8 (defaults to npu_pkg::APB_D_W)
//   N_SLV        4                number of downstream slaves, 1..16
//   SLV_BASE     {N_SLV{32'h0}}   packed N_SLV*APB_A_W window base addresses, slot i at [i*APB_A_W +: APB_A_W]
//   SLV_MASK     {N_SLV{32'h0}}   packed N_SLV*APB_A_W window masks; hit_i = (addr & MASK_i) == BASE_i
//   TIMEOUT_CYC  256              ACCESS-phase wait limit in cycles, >=2 (used only with NPU_APB_TIMEOUT_EN)
// PORTS
//   clk_i        in   1               clock
//   rst_i        in   1               synchronous reset, active-high
//   s_p_addr     in   APB_A_W         upstream address
//   s_p_sel      in   1               upstream select
//   s_p_enable   in   1               upstream enable
//   s_p_write    in   1               1-write / 0-read
//   s_p_wdata    in   APB_D_W         upstream write data
//   s_p_strb     in   APB_D_W/8       upstream write strobes
//   s_p_ready    out  1               upstream ready
//   s_p_rdata    out  APB_D_W         upstream read data
//   s_p_slverr   out  1               upstream error
//   m_p_addr     out  APB_A_W         downstream address, shared by all slaves
//   m_p_sel      out  N_SLV           downstream one-hot select
//   m_p_enable   out  1               downstream enable, shared
//   m_p_write    out  1               downstream direction, shared
//   m_p_wdata    out  APB_D_W         downstream write data, shared
//   m_p_strb     out  APB_D_W/8       downstream strobes; 0 on reads
//   m_p_ready    in   N_SLV           per-slave ready
//   m_p_rdata    in   N_SLV*APB_D_W   per-slave read data, slot i at [i*APB_D_W +: APB_D_W]
//   m_p_slverr   in   N_SLV           per-slave error
// BEHAVIOUR
//   - One clock (clk_i); rst_i synchronous active-high. All outputs 0 at reset; FSM resets to IDLE.
//   - FSM states: IDLE, SETUP, ACCESS, RESP, ERR. All outputs are registered.
//   - IDLE: on s_p_sel=1 && s_p_enable=0, latch addr/write/wdata/strb.
//     Decode takes the lowest-index hit: hit -> SETUP with m_p_sel[idx]=1, m_p_enable=0; miss -> ERR.
//   - SETUP: exactly 1 cycle, then ACCESS with m_p_enable=1.
//   - ACCESS: hold all m_* signals stable until m_p_ready[idx]=1.
//     Then capture m_p_rdata slot idx (0 on writes) and m_p_slverr[idx]; clear m_p_sel/m_p_enable; go to RESP.
//   - RESP: s_p_ready=1 for exactly 1 cycle with the captured s_p_rdata/s_p_slverr, then IDLE.
//   - ERR: s_p_ready=1, s_p_slverr=1, s_p_rdata=0 for 1 cycle, then IDLE. No downstream select is asserted.
//   - s_p_ready=0 and s_p_slverr=0 in all states other than RESP/ERR. s_p_rdata is 0 outside RESP.
//   - Latency, 0-wait slave, upstream SETUP at cycle 0: m_p_sel at 1, m_p_enable at 2, s_p_ready at 3.
//     Miss: s_p_ready at cycle 1.
//   - Back-to-back: a new upstream SETUP in the cycle after RESP/ERR is accepted; there is no idle gap.
//   - Upstream s_p_sel dropped mid-transfer: the downstream transfer still completes and the response is discarded.
//   - Reset mid-transfer: m_p_sel/m_p_enable go to 0 at the next edge; the pending transfer is abandoned.
//   - Overlapping windows are legal; the lower index wins. N_SLV=1 is legal.
// CONFIGURATION
//   NPU_APB_TIMEOUT_EN defined:
//     - A counter clears on ACCESS entry and increments each ACCESS cycle without ready.
//     - At count TIMEOUT_CYC-1 with no ready: drop m_p_sel/m_p_enable, go to RESP with s_p_slverr=1 and s_p_rdata=0.
//     - A ready arriving in that same cycle wins and the transfer completes normally.
//   NPU_APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for ready.
// TESTING
//   1. N_SLV=4, base i*0x1000, mask 0xF000. Read 0x2004, slave2 0-wait rdata 0xA5A5_0002
//      -> m_p_sel=4'b0100, s_p_ready at cycle 3, s_p_rdata=0xA5A5_0002, slverr=0.
//   2. Write 0x3010 data 0xDEAD_BEEF strb 4'b0011, slave3 with 5 wait states
//      -> m_p_wdata/strb held stable; s_p_ready at cycle 8; slverr=0.
//   3. Access 0x8000 (miss) -> no m_p_sel, s_p_ready=1 and s_p_slverr=1 at cycle 1, s_p_rdata=0.
//   4. NPU_APB_TIMEOUT_EN, TIMEOUT_CYC=8, slave1 never ready
//      -> m_p_sel cleared after 8 ACCESS cycles, s_p_slverr=1; a retry to slave0 then succeeds.
//   5. rst_i asserted during ACCESS of slave0 -> all outputs 0 next cycle; next read to slave1 completes normally.
//   6. Back-to-back read slave0 then write slave1 with 0-wait slaves, plus slave m_p_slverr=1 on the write
//      -> second s_p_ready 4 cycles after first, with s_p_slverr=1.

Source files
------------

// File: rtl/npu_apb_splitter.sv
`default_nettype none
// ============================================================================
// Module   : npu_apb_splitter
// Brief    : APB4 1-to-N splitter with address-window decode and a registered
//            SETUP/ACCESS sequence. Optional ACCESS timeout: NPU_APB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module npu_apb_splitter #(
    parameter int                       APB_A_W     = 32,
    parameter int                       APB_D_W     = 32,
    parameter int                       N_SLV       = 4,
    parameter logic [N_SLV*APB_A_W-1:0] SLV_BASE    = '0,
    parameter logic [N_SLV*APB_A_W-1:0] SLV_MASK    = '0,
    parameter int                       TIMEOUT_CYC = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [APB_A_W-1:0]       s_p_addr,
    input  logic                     s_p_sel,
    input  logic                     s_p_enable,
    input  logic                     s_p_write,
    input  logic [APB_D_W-1:0]       s_p_wdata,
    input  logic [APB_D_W/8-1:0]     s_p_strb,
    output logic                     s_p_ready,
    output logic [APB_D_W-1:0]       s_p_rdata,
    output logic                     s_p_slverr,
    output logic [APB_A_W-1:0]       m_p_addr,
    output logic [N_SLV-1:0]         m_p_sel,
    output logic                     m_p_enable,
    output logic                     m_p_write,
    output logic [APB_D_W-1:0]       m_p_wdata,
    output logic [APB_D_W/8-1:0]     m_p_strb,
    input  logic [N_SLV-1:0]         m_p_ready,
    input  logic [N_SLV*APB_D_W-1:0] m_p_rdata,
    input  logic [N_SLV-1:0]         m_p_slverr
);

    localparam int STRB_W = APB_D_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RESP   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    if (N_SLV < 1 || N_SLV > 16 || TIMEOUT_CYC < 2) begin : g_param_chk
        $error("npu_apb_splitter: N_SLV must be 1..16 and TIMEOUT_CYC >= 2");
    end

    state_t               r_state, w_state_nxt;
    logic [APB_A_W-1:0]   r_m_addr, w_m_addr;
    logic [N_SLV-1:0]     r_m_sel, w_m_sel;
    logic                 r_m_enable, w_m_enable;
    logic                 r_m_write, w_m_write;
    logic [APB_D_W-1:0]   r_m_wdata, w_m_wdata;
    logic [STRB_W-1:0]    r_m_strb, w_m_strb;
    logic                 r_s_ready, w_s_ready;
    logic [APB_D_W-1:0]   r_s_rdata, w_s_rdata;
    logic                 r_s_slverr, w_s_slverr;
    logic                 r_drop, w_drop;

    logic [N_SLV-1:0]     w_hit_sel;
    logic [APB_D_W-1:0]   w_slv_rdata;
    logic                 w_slv_ready;
    logic                 w_slv_err;
    logic                 w_timeout;

    // Walk from the top index down so the lowest-index hit is the one kept.
    always_comb begin
        w_hit_sel = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((s_p_addr & SLV_MASK[i*APB_A_W +: APB_A_W]) == SLV_BASE[i*APB_A_W +: APB_A_W]) begin
                w_hit_sel    = '0;
                w_hit_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_slv_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (r_m_sel[i]) w_slv_rdata = w_slv_rdata | m_p_rdata[i*APB_D_W +: APB_D_W];
        end
    end

    assign w_slv_ready = |(m_p_ready & r_m_sel);
    assign w_slv_err   = |(m_p_slverr & r_m_sel);

`ifdef NPU_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || r_state != ST_ACCESS) r_cnt <= '0;
        else if (!w_slv_ready)             r_cnt <= r_cnt + CNT_W'(1);
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_m_addr    = r_m_addr;
        w_m_sel     = r_m_sel;
        w_m_enable  = r_m_enable;
        w_m_write   = r_m_write;
        w_m_wdata   = r_m_wdata;
        w_m_strb    = r_m_strb;
        w_s_ready   = 1'b0;
        w_s_rdata   = '0;
        w_s_slverr  = 1'b0;
        w_drop      = r_drop;
        case (r_state)
            ST_IDLE: begin
                w_drop = 1'b0;
                if (s_p_sel && !s_p_enable) begin
                    w_m_addr  = s_p_addr;
                    w_m_write = s_p_write;
                    w_m_wdata = s_p_wdata;
                    w_m_strb  = s_p_write ? s_p_strb : '0;
                    if (|w_hit_sel) begin
                        w_m_sel     = w_hit_sel;
                        w_m_enable  = 1'b0;
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_s_ready   = 1'b1;
                        w_s_slverr  = 1'b1;
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_SETUP: begin
                w_m_enable  = 1'b1;
                w_drop      = r_drop | !s_p_sel;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                // An upstream that walked away still lets the slave finish, but gets no reply.
                w_drop = r_drop | !s_p_sel;
                if (w_slv_ready || w_timeout) begin
                    w_m_sel     = '0;
                    w_m_enable  = 1'b0;
                    w_state_nxt = w_drop ? ST_IDLE : ST_RESP;
                    if (!w_drop) begin
                        w_s_ready  = 1'b1;
                        w_s_slverr = w_slv_ready ? w_slv_err : 1'b1;
                        w_s_rdata  = (w_slv_ready && !r_m_write) ? w_slv_rdata : '0;
                    end
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_m_addr   <= '0;
            r_m_sel    <= '0;
            r_m_enable <= 1'b0;
            r_m_write  <= 1'b0;
            r_m_wdata  <= '0;
            r_m_strb   <= '0;
            r_s_ready  <= 1'b0;
            r_s_rdata  <= '0;
            r_s_slverr <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_m_addr   <= w_m_addr;
            r_m_sel    <= w_m_sel;
            r_m_enable <= w_m_enable;
            r_m_write  <= w_m_write;
            r_m_wdata  <= w_m_wdata;
            r_m_strb   <= w_m_strb;
            r_s_ready  <= w_s_ready;
            r_s_rdata  <= w_s_rdata;
            r_s_slverr <= w_s_slverr;
            r_drop     <= w_drop;
        end
    end

    assign s_p_ready  = r_s_ready;
    assign s_p_rdata  = r_s_rdata;
    assign s_p_slverr = r_s_slverr;
    assign m_p_addr   = r_m_addr;
    assign m_p_sel    = r_m_sel;
    assign m_p_enable = r_m_enable;
    assign m_p_write  = r_m_write;
    assign m_p_wdata  = r_m_wdata;
    assign m_p_strb   = r_m_strb;

endmodule
`default_nettype wire

// File: tb/tb_npu_apb_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_npu_apb_splitter
// Brief    : Self-checking bench for npu_apb_splitter, 4 slaves at i*0x1000.
// Revision : 1.0 - initial release
// ============================================================================
module tb_npu_apb_splitter;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   s_p_addr;
    logic          s_p_sel, s_p_enable, s_p_write;
    logic [31:0]   s_p_wdata;
    logic [3:0]    s_p_strb;
    logic          s_p_ready;
    logic [31:0]   s_p_rdata;
    logic          s_p_slverr;
    logic [31:0]   m_p_addr;
    logic [N-1:0]  m_p_sel;
    logic          m_p_enable, m_p_write;
    logic [31:0]   m_p_wdata;
    logic [3:0]    m_p_strb;
    logic [N-1:0]  m_p_ready;
    logic [N*32-1:0] m_p_rdata;
    logic [N-1:0]  m_p_slverr;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] win_base [N] = '{32'h0000, 32'h1000, 32'h2000, 32'h3000};
    logic [31:0] win_mask [N] = '{32'hF000, 32'hF000, 32'hF000, 32'hF000};
    logic [31:0] slv_rd   [N];

    npu_apb_splitter #(
        .APB_A_W    (32),
        .APB_D_W    (32),
        .N_SLV      (N),
        .SLV_BASE   ({32'h3000, 32'h2000, 32'h1000, 32'h0000}),
        .SLV_MASK   ({4{32'h0000_F000}}),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_p_addr(s_p_addr), .s_p_sel(s_p_sel), .s_p_enable(s_p_enable),
        .s_p_write(s_p_write), .s_p_wdata(s_p_wdata), .s_p_strb(s_p_strb),
        .s_p_ready(s_p_ready), .s_p_rdata(s_p_rdata), .s_p_slverr(s_p_slverr),
        .m_p_addr(m_p_addr), .m_p_sel(m_p_sel), .m_p_enable(m_p_enable),
        .m_p_write(m_p_write), .m_p_wdata(m_p_wdata), .m_p_strb(m_p_strb),
        .m_p_ready(m_p_ready), .m_p_rdata(m_p_rdata), .m_p_slverr(m_p_slverr)
    );

    always #5 clk = ~clk;

    // One upstream transfer starting at the next edge; the slave side is emulated,
    // and every cycle is compared with what the address map and wait count imply.
    task automatic run_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                            input logic [3:0] st, input int waits, input bit serr, input bit rnd_rd);
        int idx, lat, acc;
        bit tmo, exp_err;
        logic [N-1:0] exp_sel, esel;
        logic [31:0]  exp_rd, erd;
        logic [3:0]   exp_strb;
        logic [31:0]  tmp;
        idx = -1;
        for (int i = N - 1; i >= 0; i--)
            if ((addr & win_mask[i]) == win_base[i]) idx = i;
        tmo = 1'b0;
`ifdef NPU_APB_TIMEOUT_EN
        tmo = (idx >= 0) && (waits >= TMO);
`endif
        lat      = (idx < 0) ? 1 : (tmo ? 2 + TMO : 3 + waits);
        exp_sel  = (idx < 0) ? '0 : N'(1 << idx);
        for (int i = 0; i < N; i++) slv_rd[i] = rnd_rd ? $urandom : (32'hA5A5_0000 | 32'(i));
        m_p_rdata = {slv_rd[3], slv_rd[2], slv_rd[1], slv_rd[0]};
        exp_rd   = (idx >= 0 && !wr && !tmo) ? slv_rd[idx] : 32'h0;
        exp_err  = (idx < 0) || tmo || serr;
        exp_strb = wr ? st : 4'h0;
        tmp = $urandom;
        m_p_slverr = tmp[N-1:0];
        if (idx >= 0) m_p_slverr[idx] = serr;
        acc = 0;
        @(posedge clk); #1;
        s_p_sel = 1'b1; s_p_enable = 1'b0; s_p_addr = addr;
        s_p_write = wr; s_p_wdata = wd; s_p_strb = st;
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            s_p_enable = 1'b1;
            tmp = $urandom;
            m_p_ready = tmp[N-1:0] & ~exp_sel;
            if (m_p_enable && (m_p_sel & exp_sel) != '0) begin
                acc++;
                if (acc > waits) m_p_ready = m_p_ready | exp_sel;
            end
            @(negedge clk);
            esel = (c < lat) ? exp_sel : '0;
            erd  = (c == lat) ? exp_rd : 32'h0;
            n_vec++;
            if ({m_p_sel, m_p_enable, s_p_ready, s_p_slverr, s_p_rdata} !==
                {esel, (idx >= 0 && c >= 2 && c < lat), (c == lat), (c == lat) && exp_err, erd}) begin
                n_err++;
                $display("FAIL xfer addr=%h cyc=%0d: got sel=%b en=%b rdy=%b err=%b rd=%h, want sel=%b en=%b rdy=%b err=%b rd=%h",
                         addr, c, m_p_sel, m_p_enable, s_p_ready, s_p_slverr, s_p_rdata,
                         esel, (idx >= 0 && c >= 2 && c < lat), (c == lat), (c == lat) && exp_err, erd);
            end
            if (c < lat && idx >= 0) begin
                n_vec++;
                if ({m_p_addr, m_p_write, m_p_wdata, m_p_strb} !== {addr, wr, wd, exp_strb}) begin
                    n_err++;
                    $display("FAIL xfer_hold cyc=%0d: got addr=%h wr=%b wd=%h strb=%b, want addr=%h wr=%b wd=%h strb=%b",
                             c, m_p_addr, m_p_write, m_p_wdata, m_p_strb, addr, wr, wd, exp_strb);
                end
            end
        end
        m_p_ready = '0;
    endtask

    task automatic go_idle(input int n);
        @(posedge clk); #1;
        s_p_sel = 1'b0; s_p_enable = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_p_sel = 0; s_p_enable = 0; s_p_write = 0; s_p_addr = '0; s_p_wdata = '0; s_p_strb = '0;
        m_p_ready = '0; m_p_rdata = '0; m_p_slverr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({s_p_ready, s_p_rdata, s_p_slverr, m_p_addr, m_p_sel, m_p_enable, m_p_write, m_p_wdata, m_p_strb} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b err=%b sel=%b en=%b addr=%h, want all zero",
                     s_p_ready, s_p_slverr, m_p_sel, m_p_enable, m_p_addr);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_directed();
        run_xfer(32'h0000_2004, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);
        go_idle(2);
        run_xfer(32'h0000_3010, 1'b1, 32'hDEAD_BEEF, 4'b0011, 5, 1'b0, 1'b0);
        go_idle(2);
        run_xfer(32'h0000_8000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b0);
        go_idle(2);
    endtask

    task automatic test_timeout();
`ifdef NPU_APB_TIMEOUT_EN
        run_xfer(32'h0000_1008, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 1'b1);
        run_xfer(32'h0000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b1);
        go_idle(2);
        run_xfer(32'h0000_1008, 1'b1, 32'h1234_5678, 4'hF, TMO - 1, 1'b0, 1'b1);
`else
        run_xfer(32'h0000_1008, 1'b0, 32'h0, 4'h0, 12, 1'b0, 1'b1);
`endif
        go_idle(2);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        s_p_sel = 1'b1; s_p_enable = 1'b0; s_p_addr = 32'h0000_0040; s_p_write = 1'b0;
        m_p_ready = '0;
        @(posedge clk); #1 s_p_enable = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if ({m_p_sel, m_p_enable} !== {4'b0001, 1'b1}) begin
            n_err++;
            $display("FAIL reset_mid_access: got sel=%b en=%b, want sel=0001 en=1", m_p_sel, m_p_enable);
        end
        @(posedge clk); #1;
        rst = 1'b1; s_p_sel = 1'b0; s_p_enable = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if ({s_p_ready, s_p_rdata, s_p_slverr, m_p_addr, m_p_sel, m_p_enable, m_p_write, m_p_wdata, m_p_strb} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_clear: got sel=%b en=%b rdy=%b, want all zero", m_p_sel, m_p_enable, s_p_ready);
        end
        @(posedge clk); #1 rst = 1'b0;
        run_xfer(32'h0000_1100, 1'b0, 32'h0, 4'h0, 1, 1'b0, 1'b1);
        go_idle(2);
    endtask

    task automatic test_back_to_back();
        run_xfer(32'h0000_0020, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b1);
        run_xfer(32'h0000_1020, 1'b1, 32'hCAFE_F00D, 4'hF, 0, 1'b1, 1'b1);
        run_xfer(32'h0001_0000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 1'b1);
        run_xfer(32'h0000_2ABC, 1'b0, 32'h0, 4'h0, 2, 1'b0, 1'b1);
        go_idle(2);
    endtask

    task automatic test_drop();
        @(posedge clk); #1;
        s_p_sel = 1'b1; s_p_enable = 1'b0; s_p_addr = 32'h0000_2100; s_p_write = 1'b1;
        s_p_wdata = 32'h0BAD_0BAD; s_p_strb = 4'hF; m_p_ready = '0; m_p_slverr = '0;
        @(posedge clk); #1 s_p_enable = 1'b1;
        @(posedge clk); #1 s_p_sel = 1'b0; s_p_enable = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({m_p_sel, m_p_enable} !== {4'b0100, 1'b1}) begin
            n_err++;
            $display("FAIL drop_access: got sel=%b en=%b, want sel=0100 en=1", m_p_sel, m_p_enable);
        end
        @(posedge clk); #1 m_p_ready = 4'b0100;
        @(negedge clk);
        n_vec++;
        if ({m_p_sel, m_p_enable, m_p_wdata} !== {4'b0100, 1'b1, 32'h0BAD_0BAD}) begin
            n_err++;
            $display("FAIL drop_hold: got sel=%b en=%b wd=%h, want sel=0100 en=1 wd=0bad0bad", m_p_sel, m_p_enable, m_p_wdata);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1 m_p_ready = '0;
            @(negedge clk);
            n_vec++;
            if ({m_p_sel, m_p_enable, s_p_ready, s_p_slverr} !== '0) begin
                n_err++;
                $display("FAIL drop_discard k=%0d: got sel=%b en=%b rdy=%b err=%b, want all zero",
                         k, m_p_sel, m_p_enable, s_p_ready, s_p_slverr);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int t = 0; t < 60; t++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = {18'h0, a[13:0]};
            run_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 1) != 0) go_idle($urandom_range(1, 3));
        end
        go_idle(2);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
